// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
package counter_pkg;

    // Count direction as presented on up_dn
    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    // End-of-range behaviour selected by the SATURATE parameter
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Bits needed to hold a prescaler value 0..presc-1, never less than one bit
    function automatic int presc_width(input int presc);
        int w;
        w = 1;
        while ((64'd1 << w) < 64'(presc)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/param_updown_counter_prescale_tick.sv
// Prescaler: turns the count enable into a one-cycle tick every PRESCALE
// enabled cycles. A partial prescale survives en=0 and is discarded by clr.
import counter_pkg::*;

module prescale_tick #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            PW   = presc_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $fatal(1, "prescale_tick: PRESCALE must be in 1..65535");
    end

    logic [PW-1:0] pcnt_p0;

    // Tick fires on the enabled cycle that completes the prescale period;
    // with PRESCALE=1 LAST is zero and the tick simply follows en.
    assign tick = en && (pcnt_p0 == LAST);

    // Prescale counter: advances only while enabled, restarts after each tick
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            pcnt_p0 <= '0;
        end else if (en) begin
            if (pcnt_p0 == LAST) begin
                pcnt_p0 <= '0;
            end else begin
                pcnt_p0 <= pcnt_p0 + PW'(1);
            end
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// Fully synchronous up/down counter with programmable modulus, prescaled
// enable, clamped parallel load, wrap/saturate end handling and status flags.
import counter_pkg::*;

module param_updown_counter #(
    parameter int     WIDTH    = 4,
    parameter longint MODULUS  = 16,
    parameter int     PRESCALE = 1,
    parameter int     SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    // Illegal parameter combinations stop elaboration
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "param_updown_counter: WIDTH must be in 1..32");
    end
    if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $fatal(1, "param_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $fatal(1, "param_updown_counter: PRESCALE must be in 1..65535");
    end
    if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
        $fatal(1, "param_updown_counter: SATURATE must be 0 or 1");
    end

    // Top of the count range, held at counter width for every comparison
    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] cnt_p0;
    logic             wrap_p0;
    logic             ovf_p0;
    logic             tick;
    logic             at_end;

    // Value taken on a tick; at a range end it either wraps to the opposite
    // end or saturates. Explicit end tests keep the count inside 0..MODULUS-1
    // for any modulus, without relying on WIDTH-bit rollover.
    function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] cur,
                                                    input logic             dir);
        logic [WIDTH-1:0] nxt;
        if (dir == CNT_UP) begin
            if (cur == CNT_MAX) begin
                nxt = (SATURATE == MODE_SAT) ? CNT_MAX : '0;
            end else begin
                nxt = cur + WIDTH'(1);
            end
        end else begin
            if (cur == '0) begin
                nxt = (SATURATE == MODE_SAT) ? '0 : CNT_MAX;
            end else begin
                nxt = cur - WIDTH'(1);
            end
        end
        return nxt;
    endfunction

    // Parallel load saturates to the top of the range
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] val);
        return (val > CNT_MAX) ? CNT_MAX : val;
    endfunction

    // Both clear and load restart the prescale period
    prescale_tick #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .clk   (clk),
        .reset (reset),
        .clr   (clear | load),
        .en    (en),
        .tick  (tick)
    );

    // Sitting at the end of the range in the current direction; a tick taken
    // here is a boundary event, whether it wraps or saturates.
    assign at_end = ((up_dn == CNT_UP) && (cnt_p0 == CNT_MAX)) ||
                    ((up_dn == CNT_DN) && (cnt_p0 == '0));

    assign tc    = at_end;
    assign count = cnt_p0;
    assign wrap  = wrap_p0;
    assign ovf   = ovf_p0;

    // Count register and status flags: reset > clear > load > tick > hold
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_p0  <= '0;
            wrap_p0 <= 1'b0;
            ovf_p0  <= 1'b0;
        end else if (load) begin
            cnt_p0  <= clamp_load(load_val);
            wrap_p0 <= 1'b0;
        end else if (tick) begin
            cnt_p0  <= step_count(cnt_p0, up_dn);
            wrap_p0 <= at_end;
            if (at_end) begin
                ovf_p0 <= 1'b1;
            end
        end else begin
            wrap_p0 <= 1'b0;
        end
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: four instances cover the default
// wrap counter, a modulus-10 down counter, a saturating counter and a
// prescaled counter.
module tb_param_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] reset_v;
    logic [3:0] en_v;
    logic [3:0] up_v;
    logic [3:0] clr_v;
    logic [3:0] ld_v;
    logic [3:0] lv   [4];
    logic [3:0] cnt  [4];
    logic [3:0] tc_v;
    logic [3:0] wrap_v;
    logic [3:0] ovf_v;

    int n_chk = 0;
    int n_err = 0;

    param_updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1), .SATURATE(0)) u_def (
        .clk(clk), .reset(reset_v[0]), .en(en_v[0]), .up_dn(up_v[0]), .clear(clr_v[0]),
        .load(ld_v[0]), .load_val(lv[0]), .count(cnt[0]), .tc(tc_v[0]), .wrap(wrap_v[0]), .ovf(ovf_v[0]));

    param_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u_m10 (
        .clk(clk), .reset(reset_v[1]), .en(en_v[1]), .up_dn(up_v[1]), .clear(clr_v[1]),
        .load(ld_v[1]), .load_val(lv[1]), .count(cnt[1]), .tc(tc_v[1]), .wrap(wrap_v[1]), .ovf(ovf_v[1]));

    param_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset_v[2]), .en(en_v[2]), .up_dn(up_v[2]), .clear(clr_v[2]),
        .load(ld_v[2]), .load_val(lv[2]), .count(cnt[2]), .tc(tc_v[2]), .wrap(wrap_v[2]), .ovf(ovf_v[2]));

    param_updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(3), .SATURATE(0)) u_pre (
        .clk(clk), .reset(reset_v[3]), .en(en_v[3]), .up_dn(up_v[3]), .clear(clr_v[3]),
        .load(ld_v[3]), .load_val(lv[3]), .count(cnt[3]), .tc(tc_v[3]), .wrap(wrap_v[3]), .ovf(ovf_v[3]));

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Compare count, wrap and ovf of one instance in one go
    task automatic check_st(input int idx, input string tag, input int c, input int w, input int o);
        check($sformatf("%s count", tag), int'(cnt[idx]), c);
        check($sformatf("%s wrap", tag), int'(wrap_v[idx]), w);
        check($sformatf("%s ovf", tag), int'(ovf_v[idx]), o);
    endtask

    // Advance n rising edges; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_c;
        int prev;

        reset_v = 4'hF;
        en_v    = 4'h0;
        up_v    = 4'hF;
        clr_v   = 4'h0;
        ld_v    = 4'h0;
        for (int i = 0; i < 4; i++) lv[i] = 4'd0;

        // Reset state of every instance
        step(2);
        for (int i = 0; i < 4; i++) check_st(i, $sformatf("reset[%0d]", i), 0, 0, 0);
        check("reset tc up", int'(tc_v[0]), 0);
        up_v[0] = 1'b0;
        #1;
        check("reset tc down", int'(tc_v[0]), 1);
        up_v[0] = 1'b1;
        #1;
        check("reset tc back up", int'(tc_v[0]), 0);
        reset_v = 4'h0;

        // Default counter: 0..15 then wrap to 0
        en_v[0] = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step(1);
            check($sformatf("def up %0d", k), int'(cnt[0]), k);
            check($sformatf("def tc %0d", k), int'(tc_v[0]), (k == 15) ? 1 : 0);
        end
        check_st(0, "def at 15", 15, 0, 0);
        step(1);
        check_st(0, "def wrap", 0, 1, 1);
        step(1);
        check_st(0, "def after wrap", 1, 0, 1);
        en_v[0] = 1'b0;

        // Modulus 10, counting down from reset
        up_v[1] = 1'b0;
        en_v[1] = 1'b1;
        exp_c = 0;
        for (int k = 0; k < 12; k++) begin
            step(1);
            prev  = exp_c;
            exp_c = (prev == 0) ? 9 : prev - 1;
            check($sformatf("m10 dn %0d count", k), int'(cnt[1]), exp_c);
            check($sformatf("m10 dn %0d wrap", k), int'(wrap_v[1]), (prev == 0) ? 1 : 0);
            check($sformatf("m10 dn %0d tc", k), int'(tc_v[1]), (exp_c == 0) ? 1 : 0);
            check($sformatf("m10 dn %0d range", k), (cnt[1] <= 4'd9) ? 1 : 0, 1);
        end
        en_v[1] = 1'b0;
        ld_v[1] = 1'b1;
        lv[1]   = 4'd12;
        step(1);
        check_st(1, "m10 load 12 clamp", 9, 0, 1);
        lv[1] = 4'd5;
        step(1);
        check_st(1, "m10 load 5", 5, 0, 1);
        ld_v[1] = 1'b0;

        // Saturating modulus 10: up from 7 holds at 9, then turns down
        ld_v[2] = 1'b1;
        lv[2]   = 4'd7;
        step(1);
        check_st(2, "sat load 7", 7, 0, 0);
        ld_v[2] = 1'b0;
        en_v[2] = 1'b1;
        up_v[2] = 1'b1;
        step(1);
        check_st(2, "sat up 8", 8, 0, 0);
        step(1);
        check_st(2, "sat up 9", 9, 0, 0);
        check("sat tc at 9", int'(tc_v[2]), 1);
        step(1);
        check_st(2, "sat hold 9 a", 9, 1, 1);
        step(1);
        check_st(2, "sat hold 9 b", 9, 1, 1);
        up_v[2] = 1'b0;
        step(1);
        check_st(2, "sat down 8", 8, 0, 1);
        en_v[2] = 1'b0;
        step(1);
        check_st(2, "sat idle", 8, 0, 1);
        ld_v[2] = 1'b1;
        lv[2]   = 4'd0;
        step(1);
        ld_v[2] = 1'b0;
        en_v[2] = 1'b1;
        step(1);
        check_st(2, "sat hold 0", 0, 1, 1);
        en_v[2] = 1'b0;

        // Prescale 3: one increment per three enabled cycles
        en_v[3] = 1'b1;
        up_v[3] = 1'b1;
        step(1); check("pre c1", int'(cnt[3]), 0);
        step(1); check("pre c2", int'(cnt[3]), 0);
        step(1); check("pre c3", int'(cnt[3]), 1);
        step(1); check("pre c4", int'(cnt[3]), 1);
        step(1); check("pre c5", int'(cnt[3]), 1);
        step(1); check("pre c6", int'(cnt[3]), 2);
        step(2); check("pre partial", int'(cnt[3]), 2);
        en_v[3] = 1'b0;
        step(5); check("pre en low hold", int'(cnt[3]), 2);
        en_v[3] = 1'b1;
        step(1); check_st(3, "pre resume tick", 3, 0, 0);

        // Build ovf=1, then reset+load+clear together
        en_v[3] = 1'b0;
        ld_v[3] = 1'b1;
        lv[3]   = 4'd15;
        step(1);
        ld_v[3] = 1'b0;
        en_v[3] = 1'b1;
        step(3);
        check_st(3, "pre wrap", 0, 1, 1);
        reset_v[3] = 1'b1;
        clr_v[3]   = 1'b1;
        ld_v[3]    = 1'b1;
        lv[3]      = 4'd9;
        step(1);
        check_st(3, "rst+clr+ld", 0, 0, 0);
        reset_v[3] = 1'b0;
        clr_v[3]   = 1'b0;
        lv[3]      = 4'd15;
        step(1);
        check("pre load 15", int'(cnt[3]), 15);
        ld_v[3] = 1'b0;
        step(2);
        check("pre tc at 15", int'(tc_v[3]), 1);
        ld_v[3] = 1'b1;
        lv[3]   = 4'd6;
        step(1);
        check_st(3, "load beats tick", 6, 0, 0);
        ld_v[3] = 1'b0;
        step(2);
        check("pre restart 2", int'(cnt[3]), 6);
        step(1);
        check("pre restart 3", int'(cnt[3]), 7);

        // Clear while ovf=1 and mid-prescale
        en_v[3] = 1'b0;
        ld_v[3] = 1'b1;
        lv[3]   = 4'd15;
        step(1);
        ld_v[3] = 1'b0;
        en_v[3] = 1'b1;
        step(3);
        check_st(3, "pre wrap 2", 0, 1, 1);
        step(1);
        clr_v[3] = 1'b1;
        step(1);
        check_st(3, "clear mid", 0, 0, 0);
        clr_v[3] = 1'b0;
        step(2);
        check("clear no early tick", int'(cnt[3]), 0);
        step(1);
        check_st(3, "clear full period", 1, 0, 0);
        en_v[3] = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
